// File: rtl/dsp_mac_ctrl_pkg.sv
// Shared DSP definitions: controller state encoding and the slice opmode
// words used to start, extend and hold a multiply-accumulate chain.
package dsp_mac_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;

endpackage

// File: rtl/dsp_mac_ctrl.sv
// Dot-product controller for an externally instantiated DSP slice: streams
// operand pairs into the slice, flushes its pipeline, and returns the sum.
module dsp_mac_ctrl
  import dsp_mac_ctrl_pkg::*;
#(
  parameter int LAT   = 3,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  input  logic [47:0]      dsp_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      out_data
);

  localparam int DW = $clog2(LAT + 2);

  state_t           state, state_nx;
  logic [LEN_W-1:0] cnt;
  logic [DW-1:0]    dcnt;
  logic [7:0]       opm_next;
  logic             first;
  logic             accept;
  logic             drain_end;

  assign in_ready  = (state == FEED);
  assign accept    = in_ready & in_valid;
  assign drain_end = (state == DRAIN) && (dcnt == DW'(LAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (len != '0) ? FEED : DONE;
      FEED:  if (accept && cnt == LEN_W'(1)) state_nx = DRAIN;
      DRAIN: if (drain_end) state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The opmode for an element reaches the slice one enabled cycle after its
  // operands, so each accept issues the opmode queued by the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      dsp_a      <= '0;
      dsp_b      <= '0;
      dsp_opmode <= '0;
      dsp_ce     <= 1'b0;
      cnt        <= '0;
      dcnt       <= '0;
      opm_next   <= '0;
      first      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dsp_ce <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              cnt      <= len;
              dcnt     <= '0;
              first    <= 1'b1;
              opm_next <= OPM_HOLD;
            end else begin
              out_data  <= '0;
              out_valid <= 1'b1;
            end
          end
        end
        FEED: begin
          if (accept) begin
            dsp_a      <= in_a;
            dsp_b      <= in_b;
            dsp_ce     <= 1'b1;
            dsp_opmode <= opm_next;
            opm_next   <= first ? OPM_FIRST : OPM_ACC;
            first      <= 1'b0;
            cnt        <= cnt - LEN_W'(1);
          end else begin
            dsp_ce <= 1'b0;
          end
        end
        // LAT enabled cycles flush the last product into P; the slice is then
        // frozen for one cycle so P is captured from a stable register.
        DRAIN: begin
          dcnt <= dcnt + DW'(1);
          if (dcnt == '0) begin
            dsp_a      <= '0;
            dsp_b      <= '0;
            dsp_opmode <= opm_next;
          end else begin
            dsp_opmode <= OPM_HOLD;
          end
          if (dcnt == DW'(LAT - 1)) dsp_ce <= 1'b0;
          if (drain_end) begin
            out_data  <= dsp_p;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Bench for dsp_mac_ctrl with a behavioural DSP slice beside it; results are
// checked against a plain arithmetic dot product of the streamed operands.
module tb_dsp_mac_ctrl;
  import dsp_mac_ctrl_pkg::*;

  localparam int LAT   = 3;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [17:0]      in_a = '0;
  logic [17:0]      in_b = '0;
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce;
  logic [47:0]      dsp_p;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [47:0]      out_data;

  int assert_count = 0;
  int fail_count = 0;
  int ce_pulses = 0;
  logic signed [17:0] opa [256];
  logic signed [17:0] opb [256];
  logic [47:0] last_result;

  always #5 clk = ~clk;

  dsp_mac_ctrl #(.LAT(LAT), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_p(dsp_p), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  // Slice model: A/B register, M register and opmode register feed P, all
  // sharing one clock enable, giving three cycles from operand to P.
  logic [17:0] a_r = '0, b_r = '0;
  logic [47:0] m_r = '0, p_r = '0;
  logic [7:0]  opm_r = '0;

  always @(posedge clk) begin
    if (dsp_ce) begin
      a_r   <= dsp_a;
      b_r   <= dsp_b;
      m_r   <= {{30{a_r[17]}}, a_r} * {{30{b_r[17]}}, b_r};
      opm_r <= dsp_opmode;
      case (opm_r)
        OPM_FIRST: p_r <= m_r;
        OPM_ACC:   p_r <= p_r + m_r;
        default:   ;
      endcase
      ce_pulses <= ce_pulses + 1;
    end
  end
  assign dsp_p = p_r;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  function automatic logic [47:0] refDot(input int n);
    logic signed [63:0] acc;
    acc = 0;
    for (int i = 0; i < n; i++) acc += longint'(opa[i]) * longint'(opb[i]);
    return acc[47:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One whole job: optional input gap after element gap_at, optional
  // backpressure in DONE with stray start pulses.
  task automatic applyStimulus(input int n, input int gap_at, input int gap_len,
                               input int ready_delay, input bit poke_start);
    logic [47:0] expected;
    int k;
    int ce_before;
    expected  = refDot(n);
    ce_before = ce_pulses;
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
    if (n == 0) begin
      checkOutput("len0_valid", 64'(out_valid), 64'd1);
    end else begin
      checkOutput("feed_busy", 64'(busy), 64'd1);
      checkOutput("feed_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < n; i++) begin
        in_valid = 1'b1;
        in_a     = opa[i];
        in_b     = opb[i];
        tick();
        if (i == gap_at && i != n - 1) begin
          in_valid = 1'b0;
          for (int g = 0; g < gap_len; g++) begin
            tick();
            checkOutput("gap_ce", 64'(dsp_ce), 64'd0);
          end
        end
      end
      in_valid = 1'b0;
      checkOutput("drain_in_ready", 64'(in_ready), 64'd0);
      k = 0;
      while (!out_valid && k < 50) begin
        tick();
        k++;
      end
      checkOutput("result_latency", 64'(k), 64'(LAT + 1));
    end
    checkOutput("result_data", 64'(out_data), 64'(expected));
    last_result = out_data;
    for (int d = 0; d < ready_delay; d++) begin
      if (poke_start) begin
        start = 1'b1;
        len   = LEN_W'(7);
      end
      tick();
      start = 1'b0;
      checkOutput("hold_data", 64'(out_data), 64'(expected));
      checkOutput("hold_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_busy", 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("handshake_valid", 64'(out_valid), 64'd0);
    checkOutput("handshake_busy", 64'(busy), 64'd0);
    tick();
    checkOutput("idle_in_ready", 64'(in_ready), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    if (n == 0) checkOutput("len0_no_ce", 64'(ce_pulses - ce_before), 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_dsp_ce"}, 64'(dsp_ce), 64'd0);
    checkOutput({tag, "_dsp_a"}, 64'(dsp_a), 64'd0);
    checkOutput({tag, "_dsp_b"}, 64'(dsp_b), 64'd0);
    checkOutput({tag, "_dsp_opmode"}, 64'(dsp_opmode), 64'd0);
    checkOutput({tag, "_out_data"}, 64'(out_data), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [47:0] gapless;
    int n;
    tick();
    tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick();

    // Back-to-back len=3 job
    opa[0] = 18'sd2;  opb[0] = 18'sd3;
    opa[1] = 18'sd4;  opb[1] = 18'sd5;
    opa[2] = -18'sd1; opb[2] = 18'sd7;
    applyStimulus(3, -1, 0, 0, 1'b0);
    checkOutput("len3_is_19", 64'(last_result), 64'd19);

    // len=4 gap-free, then the same operands with a 5-cycle gap
    for (int i = 0; i < 4; i++) begin
      opa[i] = 18'($urandom);
      opb[i] = 18'($urandom);
    end
    applyStimulus(4, -1, 0, 0, 1'b0);
    gapless = last_result;
    applyStimulus(4, 2, 5, 0, 1'b0);
    checkOutput("gap_equals_gapless", 64'(last_result), 64'(gapless));

    // len=0
    applyStimulus(0, -1, 0, 0, 1'b0);

    // Backpressure in DONE with start pulses ignored
    opa[0] = -18'sd300; opb[0] = 18'sd1000;
    opa[1] = 18'sd77;   opb[1] = -18'sd5;
    applyStimulus(2, -1, 0, 10, 1'b1);

    // Reset during FEED after 2 of 5 elements
    start = 1'b1;
    len   = LEN_W'(5);
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a     = 18'(i + 11);
      in_b     = 18'(i + 3);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midjob_reset");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("post_reset_valid", 64'(out_valid), 64'd0);
    checkOutput("post_reset_busy", 64'(busy), 64'd0);
    checkOutput("post_reset_in_ready", 64'(in_ready), 64'd0);
    opa[0] = 18'sd131071;
    opb[0] = 18'sd131071;
    applyStimulus(1, -1, 0, 0, 1'b0);
    checkOutput("max_square", 64'(last_result), 64'd17179607041);

    // Full-length job of most-negative operands
    for (int i = 0; i < 255; i++) begin
      opa[i] = -18'sd131072;
      opb[i] = -18'sd131072;
    end
    applyStimulus(255, -1, 0, 0, 1'b0);
    checkOutput("len255_sum", 64'(last_result), 64'd4380866641920);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        opa[i] = 18'($urandom);
        opb[i] = 18'($urandom);
      end
      applyStimulus(n, int'($urandom_range(0, 11)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
